// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, types and helpers for the instruction fetch stage.
//   INS_W       instruction width (opcode lives in [15:12])
//   OP_HALT     opcode that stops fetching
//   OP_DEST_HI  opcodes whose destination register is in [11:8] instead of [3:0]
//   imemRsp_t   one instruction-memory response slot (valid + word)
//   dest_sel()  destination-register field of an instruction
package fetch_pkg;

  localparam int INS_W = 16;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int N_DEST_HI = 2;
  localparam logic [N_DEST_HI-1:0][3:0] OP_DEST_HI = {4'd5, 4'd4};

  typedef struct packed {
    logic             vld;
    logic [INS_W-1:0] word;
  } imemRsp_t;

  // Empty-queue head is all zeros (opcode 0 -> low field -> 0), so this
  // naturally yields 0 when nothing is valid.
  function automatic logic [3:0] dest_sel(input logic [INS_W-1:0] ins);
    logic hi;
    hi = 1'b0;
    for (int i = 0; i < N_DEST_HI; i++) begin
      if (ins[15:12] == OP_DEST_HI[i]) hi = 1'b1;
    end
    return hi ? ins[11:8] : ins[3:0];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// sync_fifo: small synchronous FIFO with registered read/write pointers and an
// explicit occupancy counter.
//   clk    clock, all state on rising edge
//   rstN   synchronous active-low reset (pointers and count to 0)
//   push   write din at tail (ignored when full)
//   din    write data
//   pop    remove head (ignored when empty)
//   dout   head entry, 0 when empty
//   full   count == DEPTH
//   empty  count == 0
//   count  occupancy, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wrPtr;
  logic [PTR_W-1:0]            rdPtr;
  logic                        doPush;
  logic                        doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  // Upstream gating already prevents overflow/underflow; the guards keep the
  // pointers coherent even if a caller misbehaves.
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = empty ? '0 : mem[rdPtr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Generates the PC, issues reads to a
// synchronous instruction memory (data one cycle after the strobe), buffers
// returned opcodes in a FIFO and hands them to decode over valid/ready.
// Stops fetching permanently on a halt opcode.
//   Clock       single clock, rising edge
//   Reset       synchronous, active-low
//   run         fetch enable (0 stops issue; buffered words still drain)
//   imem_rd_en  read strobe
//   imem_addr   read address (= PC)
//   imem_data   read data, valid the cycle after imem_rd_en
//   ins_out     head-of-queue instruction (0 when empty)
//   ins_valid   ins_out is valid
//   ins_ready   decode accepts ins_out this cycle
//   dest_out    destination field of ins_out
//   halted      halt opcode seen; sticky until Reset
//   count       FIFO occupancy
//   pc_out      current PC
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = 8,
  parameter  int INS_W = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             run,
  output logic             imem_rd_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_data,
  output logic [INS_W-1:0] ins_out,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [3:0]       dest_out,
  output logic             halted,
  output logic [CNT_W-1:0] count,
  output logic [PC_W-1:0]  pc_out
);

  import fetch_pkg::*;

  logic [PC_W-1:0]  pc;
  logic             inflight;
  logic             haltQ;
  imemRsp_t         rsp;
  logic             rspHalt;
  logic             push;
  logic             pop;
  logic             setHalt;
  logic             room;
  logic             issue;
  logic             fifoEmpty;
  logic             fifoFull;
  logic [INS_W-1:0] head;

  // The memory response slot is only meaningful the cycle after an issue.
  assign rsp     = '{vld: inflight, word: imem_data};
  assign rspHalt = (rsp.word[15:12] == OP_HALT);

  // Once halted, the one response still in flight (issued in the halt-data
  // cycle, before halted rose) is dropped along with the halt word itself.
  assign push    = rsp.vld & ~haltQ & ~rspHalt;
  assign setHalt = rsp.vld & ~haltQ & rspHalt;
  assign pop     = ins_ready & ~fifoEmpty;

  // Reserve a slot for the outstanding read so the FIFO can never overflow.
  // Uses registered count, so a pop this cycle frees room only next cycle.
  assign room  = ((CNT_W+1)'(count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH);
  // Reset gates the strobe so no read is issued while reset is held.
  assign issue = Reset & run & ~haltQ & room;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc       <= '0;
      inflight <= 1'b0;
      haltQ    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue)   pc    <= pc + PC_W'(1);
      if (setHalt) haltQ <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(INS_W),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk  (Clock),
    .rstN (Reset),
    .push (push),
    .din  (rsp.word),
    .pop  (pop),
    .dout (head),
    .full (fifoFull),
    .empty(fifoEmpty),
    .count(count)
  );

  assign imem_rd_en = issue;
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign halted     = haltQ;
  assign ins_valid  = ~fifoEmpty;
  assign ins_out    = head;
  assign dest_out   = dest_sel(head);

endmodule
